dff_sync_sr_checker: RTL and testbench
======================================

Name: dff_sync_sr_checker

Overview:
- Synthesizable self-checking monitor for a D flip-flop with synchronous set and reset. It is the response end of the flop stimulus interface.
- Snoops the flop's d/set/reset inputs and its q/qbar outputs, runs a cycle-accurate golden model, and flags every mismatch.
- Sits beside any sync set/reset flop under test, in simulation or on FPGA. Drives pass/fail and count outputs for LEDs or a status register.

Parameters:
- CNT_W, 8, width of the error and check counters. Both counters saturate at 2^CNT_W-1.
- RESET_WINS, 1, DUT priority when set and reset are both high. 1: q goes to 0. 0: q goes to 1.
- STOP_ON_FAIL, 0, 1: enter HALT on the first mismatch and freeze the counters. 0: keep checking.

Ports:
- clock  in  1  checker clock; the same clock that drives the DUT flop.
- reset  in  1  checker reset, asynchronous, active-high.
- enable  in  1  when 0, no state advance and no comparisons are made.
- clear  in  1  synchronous; zeroes both counters and fail, and returns to IDLE.
- mon_d  in  1  DUT d input.
- mon_set  in  1  DUT synchronous set.
- mon_reset  in  1  DUT synchronous reset.
- mon_q  in  1  DUT q.
- mon_qbar  in  1  DUT qbar.
- armed  out  1  high while in CHECK.
- err_pulse  out  1  one-cycle pulse on each mismatch.
- fail  out  1  sticky; set on the first mismatch.
- err_count  out  CNT_W  number of mismatching cycles.
- check_count  out  CNT_W  number of compared cycles.

Behaviour:
- reset=1 (async) forces: state=IDLE, exp_q=0, armed=0, err_pulse=0, fail=0, both counters=0.
- Golden model, updated at every posedge while enable=1:
  - set & reset both high: exp_q <= ~RESET_WINS.
  - reset only: exp_q <= 0.
  - set only: exp_q <= 1.
  - neither: exp_q <= mon_d.
  - exp_q is valid only after the DUT has seen a reset or a set.
- States:
  - IDLE: armed=0, no comparisons. When mon_reset=1 or mon_set=1 is sampled, load exp_q and go to CHECK. The DUT q is unknown before this point.
  - CHECK: armed=1. Each posedge compares mon_q against the exp_q value registered at the previous edge, and checks mon_qbar == ~mon_q. Then exp_q updates as above.
  - HALT: reached only when STOP_ON_FAIL=1. armed=0, counters frozen, fail=1. Left only by reset or clear.
- Latency: DUT inputs sampled at edge N are checked against mon_q at edge N+1. err_pulse is registered and goes high in the cycle after edge N+1.
- Per compare:
  - check_count increments by 1.
  - On a mismatch (q wrong, or qbar not the complement of q):
    - err_pulse=1, err_count increments by 1, fail=1.
    - If STOP_ON_FAIL=1, go to HALT.
- Counters saturate at all ones and do not wrap; a saturated check_count does not suppress error detection.
- If mon_q or mon_qbar is X/Z in simulation, it counts as a mismatch (case-equality compare).
- enable=0: all state and counters hold and err_pulse=0. Checking resumes from the held exp_q.
- clear=1 together with a mismatch: clear wins. Counters=0, fail=0, err_pulse=0, state=IDLE.
- Async reset asserted mid-CHECK: everything returns to reset values immediately, and the next DUT reset or set must be seen before re-arming.

Decomposition:
- Shared package flop_chk_pkg:
  - state enum (IDLE, CHECK, HALT)
  - priority constants RESET_WINS_0 and RESET_WINS_1
  - function next_q(d, set, rst, reset_wins), shared with the golden model and with other flop checkers.
- One natural sub-module: sat_counter (CNT_W, inc, clr, freeze). Instantiated twice.

Test Plan:
- Arming: hold mon_reset=0, mon_set=0, toggle d for 5 cycles -> armed=0, check_count=0. Then pulse mon_reset=1 for one cycle -> armed=1 on the next cycle, exp_q=0.
- Clean run: after arming, apply the d/set/reset sequence 0,1,set,reset,set+reset with a correct DUT (RESET_WINS=1) -> err_count=0, fail=0, check_count=5.
- Priority fault: RESET_WINS=1, apply set=1 and reset=1, DUT returns q=1 -> err_pulse high exactly one cycle after the compare edge, err_count=1, fail=1.
- qbar fault: force mon_qbar=mon_q for 3 cycles -> err_count=3, with err_pulse high for 3 consecutive cycles.
- Saturation and HALT:
  - CNT_W=4 and STOP_ON_FAIL=0, inject 20 errors -> err_count=15 and holds.
  - STOP_ON_FAIL=1, one error -> state HALT, armed=0, later errors are ignored, and clear=1 returns to IDLE with counters=0.
- Async reset mid-run: assert reset between clock edges during CHECK with err_count=2 -> all outputs are 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/flop_chk_pkg.sv
// rtl/flop_chk_pkg.sv - shared types and golden next-state rule for flop checkers
//
// Purpose: checker state encoding, set/reset priority constants and the
// reference next-q function for a D flop with synchronous set and reset.
// Ports: none (package).

package flop_chk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    HALT  = 2'd2
  } chk_state_t;

  // Value of RESET_WINS selecting which control dominates when both are high.
  localparam logic RESET_WINS_0 = 1'b0;  // set dominates, q -> 1
  localparam logic RESET_WINS_1 = 1'b1;  // reset dominates, q -> 0

  // Next q of a sync set/reset D flop given the inputs sampled at this edge.
  function automatic logic next_q(input logic d,
                                  input logic set,
                                  input logic rst,
                                  input logic reset_wins);
    logic q;
    if (set && rst) begin
      q = ~reset_wins;
    end else if (rst) begin
      q = 1'b0;
    end else if (set) begin
      q = 1'b1;
    end else begin
      q = d;
    end
    return q;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with sync clear and freeze
//
// Purpose: counts inc pulses, stops at all ones instead of wrapping.
// Ports:
//   clk    in   clock
//   rst    in   asynchronous active-high reset, count -> 0
//   clr    in   synchronous clear, count -> 0 (overrides freeze and inc)
//   inc    in   increment request
//   freeze in   hold count, ignore inc
//   count  out  CNT_W-bit count value

module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic             freeze,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !freeze && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/dff_sync_sr_checker.sv
// rtl/dff_sync_sr_checker.sv - golden-model monitor for a sync set/reset D flop
//
// Purpose: snoops a flop under test, predicts q one cycle ahead and flags
// every cycle where q is wrong or qbar is not the complement of q.
// Ports:
//   clock       in   clock shared with the flop under test
//   reset       in   asynchronous active-high checker reset
//   enable      in   0 holds all state, no comparisons
//   clear       in   synchronous; zeroes counters and fail, back to IDLE
//   mon_d       in   flop d
//   mon_set     in   flop synchronous set
//   mon_reset   in   flop synchronous reset
//   mon_q       in   flop q
//   mon_qbar    in   flop qbar
//   armed       out  high while comparing (CHECK)
//   err_pulse   out  one-cycle pulse per mismatching compare
//   fail        out  sticky mismatch flag
//   err_count   out  saturating count of mismatching compares
//   check_count out  saturating count of compares

module dff_sync_sr_checker
  import flop_chk_pkg::*;
#(
  parameter int   CNT_W        = 8,
  parameter logic RESET_WINS   = RESET_WINS_1,
  parameter logic STOP_ON_FAIL = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic             mon_d,
  input  logic             mon_set,
  input  logic             mon_reset,
  input  logic             mon_q,
  input  logic             mon_qbar,
  output logic             armed,
  output logic             err_pulse,
  output logic             fail,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] check_count
);

  chk_state_t state;
  logic       exp_q;
  logic       q_next;
  logic       seen_init;
  logic       compare;
  logic       mismatch;

  assign q_next    = next_q(mon_d, mon_set, mon_reset, RESET_WINS);
  assign seen_init = mon_set || mon_reset;

  // A compare happens on every enabled CHECK edge; clear suppresses it.
  assign compare = enable && !clear && (state == CHECK);

  // Case inequality so X/Z on the snooped outputs counts as an error in sim.
  assign mismatch = (mon_q !== exp_q) || (mon_qbar !== ~mon_q);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      exp_q     <= 1'b0;
      armed     <= 1'b0;
      err_pulse <= 1'b0;
      fail      <= 1'b0;
    end else if (clear) begin
      state     <= IDLE;
      armed     <= 1'b0;
      err_pulse <= 1'b0;
      fail      <= 1'b0;
    end else if (!enable) begin
      err_pulse <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          err_pulse <= 1'b0;
          // q is unknown until the flop has been forced by set or reset.
          if (seen_init) begin
            exp_q <= q_next;
            state <= CHECK;
            armed <= 1'b1;
          end
        end
        CHECK: begin
          exp_q     <= q_next;
          err_pulse <= mismatch;
          if (mismatch) begin
            fail <= 1'b1;
            if (STOP_ON_FAIL) begin
              state <= HALT;
              armed <= 1'b0;
            end
          end
        end
        HALT: begin
          err_pulse <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          armed     <= 1'b0;
          err_pulse <= 1'b0;
        end
      endcase
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_check_cnt (
    .clk    (clock),
    .rst    (reset),
    .clr    (clear),
    .inc    (compare),
    .freeze (state == HALT),
    .count  (check_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk    (clock),
    .rst    (reset),
    .clr    (clear),
    .inc    (compare && mismatch),
    .freeze (state == HALT),
    .count  (err_count)
  );

endmodule

// File: tb/tb_dff_sync_sr_checker.sv
// tb/tb_dff_sync_sr_checker.sv - self-checking bench for dff_sync_sr_checker

module tb_dff_sync_sr_checker;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b1;
  logic clear = 1'b0;
  logic mon_d = 1'b0;
  logic mon_set = 1'b0;
  logic mon_reset = 1'b0;

  // Reference flop (reset dominates) plus fault overrides on its outputs.
  logic fq = 1'bx;
  logic fault_q_en = 1'b0;
  logic fault_q = 1'b0;
  logic fault_qb_en = 1'b0;
  logic mon_q, mon_qbar;

  assign mon_q    = fault_q_en ? fault_q : fq;
  assign mon_qbar = fault_qb_en ? mon_q : ~mon_q;

  always #5 clock = ~clock;

  always @(posedge clock) fq <= mon_reset ? 1'b0 : (mon_set ? 1'b1 : mon_d);

  // Three checkers: 0 = keep checking, 1 = stop on fail, 2 = set dominates.
  logic        armed_o[3];
  logic        pulse_o[3];
  logic        fail_o[3];
  logic [3:0]  ec0, cc0, ec1, cc1;
  logic [7:0]  ec2, cc2;
  logic [31:0] ec_o[3];
  logic [31:0] cc_o[3];

  assign ec_o[0] = {28'd0, ec0};
  assign cc_o[0] = {28'd0, cc0};
  assign ec_o[1] = {28'd0, ec1};
  assign cc_o[1] = {28'd0, cc1};
  assign ec_o[2] = {24'd0, ec2};
  assign cc_o[2] = {24'd0, cc2};

  dff_sync_sr_checker #(.CNT_W(4), .RESET_WINS(1'b1), .STOP_ON_FAIL(1'b0)) u_run (
    .clock(clock), .reset(reset), .enable(enable), .clear(clear),
    .mon_d(mon_d), .mon_set(mon_set), .mon_reset(mon_reset),
    .mon_q(mon_q), .mon_qbar(mon_qbar),
    .armed(armed_o[0]), .err_pulse(pulse_o[0]), .fail(fail_o[0]),
    .err_count(ec0), .check_count(cc0)
  );

  dff_sync_sr_checker #(.CNT_W(4), .RESET_WINS(1'b1), .STOP_ON_FAIL(1'b1)) u_halt (
    .clock(clock), .reset(reset), .enable(enable), .clear(clear),
    .mon_d(mon_d), .mon_set(mon_set), .mon_reset(mon_reset),
    .mon_q(mon_q), .mon_qbar(mon_qbar),
    .armed(armed_o[1]), .err_pulse(pulse_o[1]), .fail(fail_o[1]),
    .err_count(ec1), .check_count(cc1)
  );

  dff_sync_sr_checker #(.CNT_W(8), .RESET_WINS(1'b0), .STOP_ON_FAIL(1'b0)) u_setwin (
    .clock(clock), .reset(reset), .enable(enable), .clear(clear),
    .mon_d(mon_d), .mon_set(mon_set), .mon_reset(mon_reset),
    .mon_q(mon_q), .mon_qbar(mon_qbar),
    .armed(armed_o[2]), .err_pulse(pulse_o[2]), .fail(fail_o[2]),
    .err_count(ec2), .check_count(cc2)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int  cmax[3]   = '{15, 15, 255};
  bit  stop_p[3] = '{1'b0, 1'b1, 1'b0};
  bit  rw_p[3]   = '{1'b1, 1'b1, 1'b0};

  bit   m_armed[3];
  bit   m_halt[3];
  bit   m_fail[3];
  bit   m_pulse[3];
  logic m_exp[3];
  int   m_err[3];
  int   m_chk[3];
  logic m_bad;

  function automatic logic rule_q(input int k);
    if (mon_set && mon_reset) return !rw_p[k];
    if (mon_reset) return 1'b0;
    if (mon_set) return 1'b1;
    return mon_d;
  endfunction

  always @(posedge clock or posedge reset) begin
    for (int k = 0; k < 3; k++) begin
      if (reset || clear) begin
        m_armed[k] = 0; m_halt[k] = 0; m_fail[k] = 0; m_pulse[k] = 0;
        m_err[k] = 0; m_chk[k] = 0;
        if (reset) m_exp[k] = 1'b0;
      end else if (!enable || m_halt[k]) begin
        m_pulse[k] = 0;
      end else if (!m_armed[k]) begin
        m_pulse[k] = 0;
        if (mon_set || mon_reset) begin
          m_exp[k] = rule_q(k);
          m_armed[k] = 1;
        end
      end else begin
        m_bad = (mon_q !== m_exp[k]) || (mon_qbar !== ~mon_q);
        m_chk[k] = (m_chk[k] < cmax[k]) ? m_chk[k] + 1 : cmax[k];
        m_pulse[k] = m_bad;
        if (m_bad) begin
          m_err[k] = (m_err[k] < cmax[k]) ? m_err[k] + 1 : cmax[k];
          m_fail[k] = 1;
          if (stop_p[k]) begin
            m_halt[k] = 1;
            m_armed[k] = 0;
          end
        end
        m_exp[k] = rule_q(k);
      end
    end
  end

  // Every-cycle comparison of all three checkers against the model.
  always @(negedge clock) begin
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("cyc_armed[%0d]", k), {31'd0, armed_o[k]}, {31'd0, m_armed[k]});
      chk($sformatf("cyc_pulse[%0d]", k), {31'd0, pulse_o[k]}, {31'd0, m_pulse[k]});
      chk($sformatf("cyc_fail[%0d]", k), {31'd0, fail_o[k]}, {31'd0, m_fail[k]});
      chk($sformatf("cyc_err[%0d]", k), ec_o[k], m_err[k]);
      chk($sformatf("cyc_chk[%0d]", k), cc_o[k], m_chk[k]);
    end
  end

  // ---------------- directed stimulus with literal expectations ----------------
  task automatic cyc(input logic d, input logic s, input logic r);
    mon_d = d; mon_set = s; mon_reset = r;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic expect_k(input string tag, input int k, input logic a, input logic p,
                          input logic f, input int ec, input int cc);
    chk({tag, $sformatf("_armed[%0d]", k)}, {31'd0, armed_o[k]}, {31'd0, a});
    chk({tag, $sformatf("_pulse[%0d]", k)}, {31'd0, pulse_o[k]}, {31'd0, p});
    chk({tag, $sformatf("_fail[%0d]", k)}, {31'd0, fail_o[k]}, {31'd0, f});
    chk({tag, $sformatf("_err[%0d]", k)}, ec_o[k], ec);
    chk({tag, $sformatf("_chk[%0d]", k)}, cc_o[k], cc);
  endtask

  initial begin
    @(negedge clock);
    @(negedge clock);
    for (int k = 0; k < 3; k++) expect_k("reset", k, 0, 0, 0, 0, 0);
    reset = 1'b0;

    // Arming: no set/reset seen, nothing compared.
    for (int i = 0; i < 5; i++) cyc(i[0], 1'b0, 1'b0);
    expect_k("idle", 0, 0, 0, 0, 0, 0);
    cyc(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) expect_k("armed", k, 1, 0, 0, 0, 0);

    // Clean run: 0, 1, set, reset, set+reset.
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) expect_k("clean", k, 1, 0, 0, 0, 5);

    // Priority fault: flop answers set+reset with q=1.
    fault_q = 1'b1; fault_q_en = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    fault_q_en = 1'b0;
    expect_k("prio", 0, 1, 1, 1, 1, 6);
    expect_k("prio", 1, 0, 1, 1, 1, 6);
    expect_k("prio", 2, 1, 0, 0, 0, 6);
    cyc(1'b0, 1'b0, 1'b0);
    expect_k("prio_after", 0, 1, 0, 1, 1, 7);
    expect_k("prio_after", 1, 0, 0, 1, 1, 6);

    // qbar tied to q for three compares.
    fault_qb_en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      cyc(1'b0, 1'b0, 1'b0);
      expect_k("qbar", 0, 1, 1, 1, 1 + i, 7 + i);
    end
    fault_qb_en = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    expect_k("qbar_after", 0, 1, 0, 1, 4, 11);
    expect_k("qbar_after", 2, 1, 0, 1, 3, 11);

    // Saturation: 20 more errors.
    fault_qb_en = 1'b1;
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, 1'b0);
    expect_k("sat", 0, 1, 1, 1, 15, 15);
    expect_k("sat", 1, 0, 0, 1, 1, 6);
    expect_k("sat", 2, 1, 1, 1, 23, 31);
    chk("model_sat_err", m_err[0], 15);
    chk("model_halted", {31'd0, m_halt[1]}, 1);

    // Clear together with a live mismatch.
    clear = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    clear = 1'b0;
    fault_qb_en = 1'b0;
    for (int k = 0; k < 3; k++) expect_k("clear", k, 0, 0, 0, 0, 0);

    // Re-arm via set, then hold with enable=0 while faulted.
    cyc(1'b0, 1'b1, 1'b0);
    expect_k("rearm", 0, 1, 0, 0, 0, 0);
    enable = 1'b0; fault_qb_en = 1'b1;
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    expect_k("disabled", 0, 1, 0, 0, 0, 0);
    enable = 1'b1; fault_qb_en = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    expect_k("resume", 0, 1, 0, 0, 0, 1);

    // Two errors, then async reset between clock edges.
    fault_qb_en = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    fault_qb_en = 1'b0;
    expect_k("pre_rst", 0, 1, 1, 1, 2, 3);
    expect_k("pre_rst", 1, 0, 0, 1, 1, 2);
    chk("model_pre_rst_err", m_err[0], 2);
    #2 reset = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) expect_k("async_rst", k, 0, 0, 0, 0, 0);
    @(negedge clock);
    reset = 1'b0;

    // Must see a set/reset again before re-arming.
    for (int i = 0; i < 3; i++) cyc(i[0], 1'b0, 1'b0);
    expect_k("post_rst_idle", 0, 0, 0, 0, 0, 0);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    expect_k("post_rst_run", 0, 1, 0, 0, 0, 2);
    expect_k("post_rst_run", 1, 1, 0, 0, 0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
